alu_operand_entry: RTL and testbench

// Input side of the ALU board demo: replaces direct switch-to-operand wiring with a sequenced

---
 rtl/alu_operand_entry.sv | 100 ++++++++++
 tb/tb_alu_operand_entry.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu_operand_entry.sv
// alu_operand_entry: debounced ENTER/UNDO sequencing that latches A, B and op_code from the switches for the ALU
// Ports: clk, reset (async active-low); sw_data switches; btn_enter/btn_undo raw buttons;
//        op_ready ALU accept; A, B, op_code captured operand set; op_valid handshake valid;
//        stage_leds one-hot stage (ENTER_A, ENTER_B, ENTER_OP, ISSUE/DONE).
module alu_operand_entry #(
  parameter int DATA_W    = 7,
  parameter int OP_W      = 2,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              btn_enter,
  input  logic              btn_undo,
  input  logic              op_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   op_code,
  output logic              op_valid,
  output logic [3:0]        stage_leds
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  typedef enum logic [2:0] {ST_A, ST_B, ST_OP, ST_ISSUE, ST_DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d, press_q, press_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic op_valid_q, op_valid_d, enter, undo;
  logic [3:0] leds_q, leds_d;
  // Bit 0 is ENTER, bit 1 is UNDO. The counter only runs while the synced level differs
  // from the stable level, so any bounce back restarts it.
  always_comb begin
    sync1_d = {btn_undo, btn_enter};
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]    = (sync2_q[i] != stable_q[i] && cnt_q[i] != CW'(DB_CYCLES - 1)) ? cnt_q[i] + 1'b1 : '0;
      stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == CW'(DB_CYCLES - 1)) ? sync2_q[i] : stable_q[i];
      press_d[i]  = stable_d[i] & ~stable_q[i];
    end
  end
  // Simultaneous enter and undo cancel each other.
  assign enter = press_q[0] & ~press_q[1];
  assign undo  = press_q[1] & ~press_q[0];
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      ST_A:     if (enter) begin a_d = sw_data; state_d = ST_B; end
      ST_B:     if (enter) begin b_d = sw_data; state_d = ST_OP; end
                else if (undo) state_d = ST_A;
      ST_OP:    if (enter) begin op_d = sw_data[OP_W-1:0]; state_d = ST_ISSUE; end
                else if (undo) state_d = ST_B;
      ST_ISSUE: if (op_valid_q && op_ready) state_d = ST_DONE;
      ST_DONE:  if (enter || undo) state_d = ST_A;
      default:  state_d = ST_A;
    endcase
    op_valid_d = state_d == ST_ISSUE;
    leds_d     = state_d == ST_A ? 4'b0001 :
                 state_d == ST_B ? 4'b0010 :
                 state_d == ST_OP ? 4'b0100 : 4'b1000;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      press_q    <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      state_q    <= ST_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      op_valid_q <= 1'b0;
      leds_q     <= 4'b0001;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      press_q    <= press_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      leds_q     <= leds_d;
    end
  end
  assign A          = a_q;
  assign B          = b_q;
  assign op_code    = op_q;
  assign op_valid   = op_valid_q;
  assign stage_leds = leds_q;
endmodule

// File: tb/tb_alu_operand_entry.sv
// tb_alu_operand_entry: scoreboard bench for alu_operand_entry with DB_CYCLES=4
module tb_alu_operand_entry;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] sw_data = '0;
  logic btn_enter = 1'b0, btn_undo = 1'b0, op_ready = 1'b0;
  logic [6:0] a, b;
  logic [1:0] op_code;
  logic op_valid;
  logic [3:0] stage_leds;
  int checks = 0, failures = 0, handshakes = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_item;
  alu_operand_entry #(.DATA_W(7), .OP_W(2), .DB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .sw_data(sw_data), .btn_enter(btn_enter), .btn_undo(btn_undo),
    .op_ready(op_ready), .A(a), .B(b), .op_code(op_code), .op_valid(op_valid), .stage_leds(stage_leds)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Handshake monitor: pops the expected operand set when the ALU accepts it.
  always @(negedge clk) begin
    if (reset && op_valid && op_ready) begin
      handshakes++;
      check("sb_nonempty", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        exp_item = exp_q.pop_front();
        check("sb_operands", {2'b00, a, b, op_code}, {2'b00, exp_item});
      end
    end
  end
  task automatic press(input logic en, input logic un, input logic [6:0] d);
    sw_data = d;
    btn_enter = en;
    btn_undo = un;
    repeat (10) @(posedge clk);
    #1;
    btn_enter = 1'b0;
    btn_undo = 1'b0;
    sw_data = 7'h7E;
    repeat (10) @(posedge clk);
    #1;
  endtask
  task automatic pulse_enter(input int n);
    btn_enter = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    btn_enter = 1'b0;
  endtask
  initial begin
    #2 reset = 1'b0;
    #1;
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_op", op_code, 0);
    check("rst_valid", op_valid, 0);
    check("rst_leds", stage_leds, 4'b0001);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back({7'h15, 7'h2A, 2'd2});
    press(1, 0, 7'h15);
    check("t2_leds_b", stage_leds, 4'b0010);
    press(1, 0, 7'h2A);
    check("t2_leds_op", stage_leds, 4'b0100);
    press(1, 0, 7'h02);
    check("t2_valid", op_valid, 1);
    check("t2_a", a, 7'h15);
    check("t2_b", b, 7'h2A);
    check("t2_op", op_code, 2);
    repeat (5) @(posedge clk);
    #1;
    check("t2_valid_held", op_valid, 1);
    check("t2_leds_issue", stage_leds, 4'b1000);
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    op_ready = 1'b0;
    check("t2_valid_drop", op_valid, 0);
    check("t2_leds_done", stage_leds, 4'b1000);
    press(1, 0, 7'h00);
    check("t3_leds_a", stage_leds, 4'b0001);
    sw_data = 7'h11;
    pulse_enter(2);
    repeat (10) @(posedge clk);
    #1;
    check("t3_glitch_leds", stage_leds, 4'b0001);
    check("t3_glitch_a", a, 7'h15);
    sw_data = 7'h11;
    pulse_enter(1);
    pulse_enter(1);
    sw_data = 7'h11;
    press(1, 0, 7'h11);
    check("t3_bounce_leds", stage_leds, 4'b0010);
    check("t3_bounce_a", a, 7'h11);
    press(1, 0, 7'h44);
    check("t4_b44", b, 7'h44);
    press(0, 1, 7'h00);
    check("t4_undo_leds", stage_leds, 4'b0010);
    press(1, 0, 7'h33);
    check("t4_b33", b, 7'h33);
    check("t4_a_kept", a, 7'h11);
    check("t4_leds_op", stage_leds, 4'b0100);
    press(0, 1, 7'h00);
    check("t5_pre_leds", stage_leds, 4'b0010);
    press(1, 1, 7'h55);
    check("t5_leds", stage_leds, 4'b0010);
    check("t5_b", b, 7'h33);
    press(1, 0, 7'h22);
    op_ready = 1'b1;
    exp_q.push_back({7'h11, 7'h22, 2'd3});
    press(1, 0, 7'h7F);
    op_ready = 1'b0;
    check("t5_one_cycle_valid", op_valid, 0);
    check("t5_leds_done", stage_leds, 4'b1000);
    check("t5_op", op_code, 3);
    press(0, 1, 7'h00);
    check("t5_undo_done", stage_leds, 4'b0001);
    press(1, 0, 7'h01);
    press(1, 0, 7'h02);
    press(1, 0, 7'h03);
    check("t6_valid_pre", op_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_valid", op_valid, 0);
    check("t6_leds", stage_leds, 4'b0001);
    check("t6_a", a, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("handshakes", handshakes, 2);
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
